// File: rtl/rom8_serial_writer.sv
// 256x1 register-file memory loaded by 9-bit serial frames {addr[7:0], data},
// with a combinational read port and a clear sweep after reset or on request.
module rom8_serial_writer #(
    parameter logic        INIT_VALUE = 1'b0,
    parameter int unsigned MSB_FIRST  = 1
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       SEN,
    input  logic       SDI,
    input  logic       CLR,
    input  logic [7:0] RADDR,
    output logic       RDATA,
    output logic       BUSY,
    output logic       WDONE,
    output logic       FRAME_ERR
);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t     r_state;
    logic [7:0] r_sweep_addr;
    logic [3:0] r_count;
    logic [7:0] r_shift;
    logic       r_busy;
    logic       r_wdone;
    logic       r_frame_err;
    logic       r_mem [0:255];

    logic [7:0] w_shift_next;
    logic [7:0] w_frame_addr;
    logic       w_frame_data;
    logic       w_commit;
    logic       w_we;
    logic [7:0] w_waddr;
    logic       w_wdata;

    // The 9th bit is taken straight from SDI so the write lands on the same edge it is sampled.
    always_comb begin
        if (MSB_FIRST != 0) begin
            w_shift_next = {r_shift[6:0], SDI};
            w_frame_addr = r_shift;
            w_frame_data = SDI;
        end else begin
            w_shift_next = {SDI, r_shift[7:1]};
            w_frame_addr = {SDI, r_shift[7:1]};
            w_frame_data = r_shift[0];
        end
    end

    assign w_commit = (r_state == S_SHIFT) && SEN && (r_count == 4'd8);

    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = 1'b0;
        if (r_state == S_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_sweep_addr;
            w_wdata = INIT_VALUE;
        end else if (w_commit) begin
            w_we    = 1'b1;
            w_waddr = w_frame_addr;
            w_wdata = w_frame_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign RDATA = r_mem[RADDR];

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state      <= S_CLEAR;
            r_sweep_addr <= '0;
            r_count      <= '0;
            r_shift      <= '0;
            r_busy       <= 1'b1;
            r_wdone      <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_wdone     <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    r_sweep_addr <= r_sweep_addr + 8'd1;
                    if (r_sweep_addr == 8'hFF) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (CLR) begin
                        r_state      <= S_CLEAR;
                        r_sweep_addr <= '0;
                        r_busy       <= 1'b1;
                    end else if (SEN) begin
                        r_shift <= w_shift_next;
                        r_count <= 4'd1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!SEN) begin
                        r_frame_err <= 1'b1;
                        r_count     <= '0;
                        r_state     <= S_IDLE;
                    end else if (r_count == 4'd8) begin
                        r_wdone <= 1'b1;
                        r_count <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_shift <= w_shift_next;
                        r_count <= r_count + 4'd1;
                    end
                end
                default: begin
                    r_state      <= S_CLEAR;
                    r_sweep_addr <= '0;
                    r_busy       <= 1'b1;
                end
            endcase
        end
    end

    assign BUSY      = r_busy;
    assign WDONE     = r_wdone;
    assign FRAME_ERR = r_frame_err;

endmodule
